// File: rtl/accum_table_if.sv
// Tile-control and accumulation-table strobe bundle between the systolic
// array sequencer (master) and the accumulation table controller (slave).
interface accum_table_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 11
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [CNT_WIDTH-1:0]  num_rows;
  logic                  accum_mode;
  logic                  in_valid;
  logic                  in_ready;
  logic                  tbl_rd_en;
  logic [ADDR_WIDTH-1:0] tbl_rd_addr;
  logic                  tbl_wr_en;
  logic [ADDR_WIDTH-1:0] tbl_wr_addr;
  logic                  add_sel;
  logic                  busy;
  logic                  done;

  modport master (
    output start, base_addr, num_rows, accum_mode, in_valid,
    input  in_ready, tbl_rd_en, tbl_rd_addr, tbl_wr_en, tbl_wr_addr,
           add_sel, busy, done
  );

  modport slave (
    input  start, base_addr, num_rows, accum_mode, in_valid,
    output in_ready, tbl_rd_en, tbl_rd_addr, tbl_wr_en, tbl_wr_addr,
           add_sel, busy, done
  );
endinterface

// File: rtl/accum_table_ctrl.sv
// Accumulation table controller: walks a tile of output rows through a
// read-modify-write (or plain write) pipeline against the table.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; tile fields latched on start
// S_RUN   | accepting rows from the array (in_ready=1)
// S_DRAIN | last row accepted; waiting for its table write to issue
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module accum_table_ctrl #(
  parameter int MAX_OUT_ROWS = 1024,
  parameter int ADDR_WIDTH   = $clog2(MAX_OUT_ROWS),
  parameter int CNT_WIDTH    = ADDR_WIDTH + 1
) (
  input logic           clk,
  input logic           reset,
  accum_table_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] MAX_ROWS_C = CNT_WIDTH'(MAX_OUT_ROWS);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [CNT_WIDTH-1:0]  rem_q;
  logic                  mode_q;
  logic                  p1_valid_q;
  logic [ADDR_WIDTH-1:0] p1_addr_q;
  logic [CNT_WIDTH-1:0]  rows_clamped;
  logic [ADDR_WIDTH-1:0] row_addr;
  logic                  start_acc;
  logic                  hs;
  logic                  last_hs;

  assign rows_clamped = (bus.num_rows > MAX_ROWS_C) ? MAX_ROWS_C : bus.num_rows;
  // Table depth is a power of two, so the natural adder wrap is the row wrap.
  assign row_addr     = base_q + idx_q;
  assign start_acc    = (state_q == S_IDLE) && bus.start;
  assign bus.in_ready = (state_q == S_RUN);
  assign hs           = bus.in_valid & bus.in_ready;
  assign last_hs      = hs && (rem_q == CNT_WIDTH'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = (rows_clamped == '0) ? S_DONE : S_RUN;
      S_RUN:   if (last_hs) state_d = S_DRAIN;
      // Once the last row has left the read stage its write is on the bus.
      S_DRAIN: if (!p1_valid_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Tile fields, row pipeline and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q          <= '0;
      idx_q           <= '0;
      rem_q           <= '0;
      mode_q          <= 1'b0;
      p1_valid_q      <= 1'b0;
      p1_addr_q       <= '0;
      bus.tbl_rd_en   <= 1'b0;
      bus.tbl_rd_addr <= '0;
      bus.tbl_wr_en   <= 1'b0;
      bus.tbl_wr_addr <= '0;
      bus.add_sel     <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      if (start_acc) begin
        base_q <= bus.base_addr;
        mode_q <= bus.accum_mode;
        rem_q  <= rows_clamped;
        idx_q  <= '0;
      end else if (hs) begin
        rem_q <= rem_q - 1'b1;
        idx_q <= idx_q + 1'b1;
      end

      // Stage 1: read issue (reads only in accumulate mode).
      p1_valid_q    <= hs;
      bus.tbl_rd_en <= hs & mode_q;
      if (hs) begin
        p1_addr_q       <= row_addr;
        bus.tbl_rd_addr <= row_addr;
      end

      // Stage 2: write issue, one cycle after the read to cover read latency.
      bus.tbl_wr_en <= p1_valid_q;
      bus.add_sel   <= p1_valid_q & mode_q;
      if (p1_valid_q) bus.tbl_wr_addr <= p1_addr_q;

      bus.busy <= (state_d != S_IDLE);
      bus.done <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_accum_table_ctrl.sv
// Self-checking bench for accum_table_ctrl: tile tasks push expected table
// strobes into queues; a negedge monitor pops and compares them every cycle.
module tb_accum_table_ctrl;
  localparam int MAX  = 1024;
  localparam int AW   = 10;
  localparam int CW   = 11;
  localparam int HUGE = 1 << 30;

  typedef struct {
    int due;
    int addr;
    bit sel;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   pass_cnt;
  int   total_cnt;
  bit   mon_en;

  exp_t rd_q[$];
  exp_t wr_q[$];
  int   done_q[$];
  int   ready_from, ready_to, busy_from, busy_to;

  accum_table_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  accum_table_ctrl #(.MAX_OUT_ROWS(MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle scoreboard comparison of every controller output.
  always @(negedge clk) begin
    exp_t e;
    logic exp_rdy, exp_busy, exp_done;
    if (mon_en) begin
      exp_rdy  = (cyc >= ready_from) && (cyc <= ready_to);
      exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
      exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
      if (exp_done) void'(done_q.pop_front());

      total_cnt++;
      if (bus.in_ready !== exp_rdy)
        $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, exp_rdy);
      else pass_cnt++;

      total_cnt++;
      if (bus.busy !== exp_busy)
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_busy);
      else pass_cnt++;

      total_cnt++;
      if (bus.done !== exp_done)
        $display("FAIL done cyc=%0d got=%b exp=%b", cyc, bus.done, exp_done);
      else pass_cnt++;

      total_cnt++;
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        e = rd_q.pop_front();
        if (bus.tbl_rd_en !== 1'b1 || bus.tbl_rd_addr !== AW'(e.addr))
          $display("FAIL read cyc=%0d got en=%b addr=%0d exp en=1 addr=%0d",
                   cyc, bus.tbl_rd_en, bus.tbl_rd_addr, e.addr);
        else pass_cnt++;
      end else begin
        if (bus.tbl_rd_en !== 1'b0)
          $display("FAIL read_idle cyc=%0d got en=%b exp en=0", cyc, bus.tbl_rd_en);
        else pass_cnt++;
      end

      total_cnt++;
      if (wr_q.size() > 0 && wr_q[0].due == cyc) begin
        e = wr_q.pop_front();
        if (bus.tbl_wr_en !== 1'b1 || bus.tbl_wr_addr !== AW'(e.addr) ||
            bus.add_sel !== e.sel)
          $display("FAIL write cyc=%0d got en=%b addr=%0d sel=%b exp en=1 addr=%0d sel=%b",
                   cyc, bus.tbl_wr_en, bus.tbl_wr_addr, bus.add_sel, e.addr, e.sel);
        else pass_cnt++;
      end else begin
        if (bus.tbl_wr_en !== 1'b0)
          $display("FAIL write_idle cyc=%0d got en=%b exp en=0", cyc, bus.tbl_wr_en);
        else pass_cnt++;
      end
    end
  end

  // Runs one tile; pat 0 holds in_valid high, pat 1 toggles it starting high.
  // rst_after > 0 pulses reset one cycle after that many handshakes.
  task automatic run_tile(input int base, input int rows, input bit accum,
                          input int pat, input bit stray, input int rst_after);
    int eff;
    int n;
    int k;
    bit v;
    eff = (rows > MAX) ? MAX : rows;
    n = 0;
    k = 0;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.base_addr  = AW'(base);
    bus.num_rows   = CW'(rows);
    bus.accum_mode = accum;
    ready_from = cyc + 1;
    busy_from  = cyc + 1;
    if (eff == 0) begin
      ready_to = cyc;
      busy_to  = cyc + 1;
      done_q.push_back(cyc + 1);
    end else begin
      ready_to = HUGE;
      busy_to  = HUGE;
    end
    @(negedge clk);
    bus.start = 1'b0;
    while (n < eff) begin
      v = (pat == 0) ? 1'b1 : (k % 2 == 0);
      bus.start     = stray && (k == 1);
      bus.base_addr = stray ? AW'(300) : AW'(base);
      bus.in_valid  = v;
      if (v) begin
        if (accum) rd_q.push_back('{cyc + 1, (base + n) % MAX, 1'b1});
        wr_q.push_back('{cyc + 2, (base + n) % MAX, accum});
        n++;
        if (n == eff) begin
          ready_to = cyc;
          busy_to  = cyc + 3;
          done_q.push_back(cyc + 3);
        end
      end
      k++;
      @(negedge clk);
      if (rst_after != 0 && n == rst_after) begin
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        reset        = 1'b1;
        while (rd_q.size() > 0 && rd_q[rd_q.size()-1].due > cyc) void'(rd_q.pop_back());
        while (wr_q.size() > 0 && wr_q[wr_q.size()-1].due > cyc) void'(wr_q.pop_back());
        ready_to = cyc;
        busy_to  = cyc;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    repeat (6) @(negedge clk);
    total_cnt++;
    if (rd_q.size() != 0 || wr_q.size() != 0 || done_q.size() != 0)
      $display("FAIL drain_empty base=%0d got rd=%0d wr=%0d done=%0d exp 0/0/0",
               base, rd_q.size(), wr_q.size(), done_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.start      = 1'b1;
    bus.in_valid   = 1'b1;
    bus.base_addr  = AW'(55);
    bus.num_rows   = CW'(3);
    bus.accum_mode = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (bus.in_ready !== 1'b0 || bus.tbl_rd_en !== 1'b0 || bus.tbl_wr_en !== 1'b0 ||
        bus.add_sel !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL reset_ctrl got rdy=%b rd=%b wr=%b sel=%b busy=%b done=%b exp all 0",
               bus.in_ready, bus.tbl_rd_en, bus.tbl_wr_en, bus.add_sel, bus.busy, bus.done);
    else pass_cnt++;
    total_cnt++;
    if (bus.tbl_rd_addr !== '0 || bus.tbl_wr_addr !== '0)
      $display("FAIL reset_addr got rd=%0d wr=%0d exp 0/0", bus.tbl_rd_addr, bus.tbl_wr_addr);
    else pass_cnt++;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_accum_basic();
    run_tile(10, 4, 1'b1, 0, 1'b0, 0);
  endtask

  task automatic test_wrap();
    run_tile(1022, 4, 1'b1, 0, 1'b0, 0);
  endtask

  task automatic test_overwrite_stall();
    run_tile(5, 3, 1'b0, 1, 1'b1, 0);
  endtask

  task automatic test_zero_rows();
    run_tile(7, 0, 1'b1, 0, 1'b0, 0);
  endtask

  task automatic test_idle_valid();
    bus.in_valid = 1'b1;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_clamp();
    run_tile(100, 2000, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_tile();
    run_tile(20, 5, 1'b1, 0, 1'b0, 2);
    repeat (2) @(negedge clk);
    run_tile(30, 2, 1'b1, 0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_tile(600, 3, 1'b1, 0, 1'b0, 0);
    run_tile(1023, 2, 1'b0, 1, 1'b0, 0);
  endtask

  initial begin
    cyc        = 0;
    pass_cnt   = 0;
    total_cnt  = 0;
    mon_en     = 1'b0;
    ready_from = HUGE;
    ready_to   = -1;
    busy_from  = HUGE;
    busy_to    = -1;
    reset      = 1'b1;
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.num_rows   = '0;
    bus.accum_mode = 1'b0;
    bus.in_valid   = 1'b0;
    test_reset();
    test_accum_basic();
    test_wrap();
    test_overwrite_stall();
    test_zero_rows();
    test_idle_valid();
    test_clamp();
    test_reset_mid_tile();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
